hwpe_cfg_initiator: RTL
=======================

# hwpe_cfg_initiator

Sequential initiator for the HWPE configuration bus: accepts single register read/write commands on a valid/ready stream, drives them onto an `XBAR_PERIPH_BUS` master port with the req/gnt handshake, waits for the matching `r_valid`/`r_id`, and returns data and status on a response stream. It sits between a cluster-side command source (core-local job sequencer or debug path) and the config slave port of the HWPE subsystem. It enforces one outstanding transaction and a response timeout.

## Interface
- `ID_WIDTH`, 8, width of `id`/`r_id` on the config bus.
- `TIMEOUT`, 1024, cycles allowed in REQ or WAIT before abort; 0 disables timeout.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command accepted when valid&ready.
- `cmd_wen_i` in 1: 1 = read, 0 = write (bus `wen` polarity).
- `cmd_add_i` in 32: register byte address.
- `cmd_wdata_i` in 32: write data.
- `cmd_be_i` in 4: byte enables.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed when valid&ready.
- `rsp_rdata_o` out 32: read data (0 for writes and errors).
- `rsp_err_o` out 1: timeout or ID mismatch.
- `busy_o` out 1: high in any state other than IDLE.
- `hwpe_cfg_master` XBAR_PERIPH_BUS.Master: `req, add, wen, be, wdata, id` out; `gnt, r_rdata, r_valid, r_id` in.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `cmd_ready_o`=1. On cmd handshake: latch wen/add/wdata/be, `id` ← `id_cnt`, `id_cnt` ← `id_cnt`+1 (mod 2^ID_WIDTH), go REQ.
- REQ: `req`=1, add/wen/be/wdata/id driven from latched registers, stable until grant. On `gnt`: go WAIT. On timeout: drop `req`, set err, go RESP.
- WAIT: `req`=0. On `r_valid`: latch `r_rdata` (reads only; writes latch 0), err = (`r_id` ≠ issued id), go RESP. On timeout: err=1, go RESP. `r_valid` outside WAIT is ignored.
- RESP: `rsp_valid_o`=1, data/err stable until `rsp_ready_i`; then go IDLE.
- Timeout counter cleared on entry to REQ and to WAIT; abort when it reaches `TIMEOUT`-1 without the awaited event. Event wins over timeout in the same cycle.
- All commands, writes included, produce exactly one response.

## Timing
- Reset values: `cmd_ready_o`=0 during reset, 1 after (IDLE); `req`=0, `add`/`wdata`/`be`/`id`=0, `wen`=1; `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `busy_o`=0; `id_cnt`=0.
- Bus outputs are registered; `req` rises the cycle after the cmd handshake.
- Min latency: cmd handshake cycle N, `req` N+1 with `gnt` N+1, `r_valid` N+2, `rsp_valid_o` N+3.
- No new command accepted until the response handshake; back-to-back minimum period 4 cycles.
- Reset mid-transaction: all state cleared asynchronously, `req` drops immediately, pending response discarded.
- `id_cnt` wraps 2^ID_WIDTH-1 → 0.

## Structure
- Package `hwpe_cfg_initiator_pkg`: state enum `cfg_state_e`, `cfg_cmd_t` struct (wen, add, wdata, be), `cfg_rsp_t` struct (rdata, err), constant `CFG_DW=32`.
- Single module; timeout counter and ID counter inline, no sub-module.

## Test plan
- Write 0x1234_5678 to 0x20, be=0xF, `gnt` immediate, `r_valid` next cycle with `r_id`=0 → bus shows add=0x20 wen=0 id=0; rsp_valid at N+3, rdata=0, err=0.
- Read 0x0C, `gnt` delayed 5 cycles, r_rdata=0xCAFE_F00D → req/add/id held stable 6 cycles; rsp rdata=0xCAFEF00D err=0.
- `r_id` returned ≠ issued id → rsp_err_o=1, rdata latched, FSM returns to IDLE.
- TIMEOUT=16, never grant → req drops after 16 REQ cycles; rsp_err=1, rdata=0; stray later `r_valid` ignored.
- 257 back-to-back commands with ID_WIDTH=8, rsp_ready held low 3 cycles each → ids 0..255,0; cmd_ready_o low while rsp pending; response data never changes while stalled.
- Assert `rst_n` low during WAIT → next cycle all outputs at reset values; post-reset command issues id=0.

Source files
------------

// File: rtl/hwpe_cfg_initiator_pkg.sv
// Shared types and constants for the HWPE configuration-bus initiator.
package hwpe_cfg_initiator_pkg;

  localparam int CFG_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } cfg_state_e;

  typedef struct packed {
    logic              wen;
    logic [CFG_DW-1:0] add;
    logic [CFG_DW-1:0] wdata;
    logic [CFG_DW/8-1:0] be;
  } cfg_cmd_t;

  typedef struct packed {
    logic [CFG_DW-1:0] rdata;
    logic              err;
  } cfg_rsp_t;

endpackage

// File: rtl/hwpe_cfg_initiator_if.sv
// Peripheral-interconnect config bus: req/gnt request channel plus r_valid/r_id response channel.
interface XBAR_PERIPH_BUS
  import hwpe_cfg_initiator_pkg::*;
#(
  parameter int ID_WIDTH = 8
);

  logic                req;
  logic [CFG_DW-1:0]   add;
  logic                wen;
  logic [CFG_DW/8-1:0] be;
  logic [CFG_DW-1:0]   wdata;
  logic [ID_WIDTH-1:0] id;
  logic                gnt;
  logic [CFG_DW-1:0]   r_rdata;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport Master (
    output req, add, wen, be, wdata, id,
    input  gnt, r_rdata, r_valid, r_id
  );

  modport Slave (
    input  req, add, wen, be, wdata, id,
    output gnt, r_rdata, r_valid, r_id
  );

endinterface

// File: rtl/hwpe_cfg_initiator.sv
// Single-outstanding config-bus initiator: command stream in, one response per command out,
// with a per-phase timeout on grant and on response.
module hwpe_cfg_initiator
  import hwpe_cfg_initiator_pkg::*;
#(
  parameter int ID_WIDTH = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_wen_i,
  input  logic [CFG_DW-1:0]   cmd_add_i,
  input  logic [CFG_DW-1:0]   cmd_wdata_i,
  input  logic [CFG_DW/8-1:0] cmd_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [CFG_DW-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  XBAR_PERIPH_BUS.Master      hwpe_cfg_master
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  cfg_state_e          r_state;
  cfg_state_e          w_nextState;
  cfg_cmd_t            r_cmd;
  cfg_rsp_t            r_rsp;
  logic [ID_WIDTH-1:0] r_id;
  logic [ID_WIDTH-1:0] r_idCnt;
  logic [TW-1:0]       r_tmo;
  logic                r_req;
  logic                r_outOfReset;
  logic                w_cmdReady;
  logic                w_cmdFire;
  logic                w_timeout;

  assign w_cmdFire = cmd_valid_i && w_cmdReady;
  // A TIMEOUT of zero never aborts; otherwise the last allowed cycle is TIMEOUT-1.
  assign w_timeout = (TIMEOUT != 0) && (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (w_cmdFire) w_nextState = ST_REQ;
      ST_REQ: begin
        if (hwpe_cfg_master.gnt)  w_nextState = ST_WAIT;
        else if (w_timeout)       w_nextState = ST_RESP;
      end
      ST_WAIT: begin
        if (hwpe_cfg_master.r_valid) w_nextState = ST_RESP;
        else if (w_timeout)          w_nextState = ST_RESP;
      end
      ST_RESP: if (rsp_ready_i) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Ready is held low while in reset and for the first edge after it.
  always_comb begin
    w_cmdReady  = r_outOfReset && (r_state == ST_IDLE);
    cmd_ready_o = w_cmdReady;
    busy_o      = (r_state != ST_IDLE);
    rsp_valid_o = (r_state == ST_RESP);
    rsp_rdata_o = r_rsp.rdata;
    rsp_err_o   = r_rsp.err;
  end

  assign hwpe_cfg_master.req   = r_req;
  assign hwpe_cfg_master.add   = r_cmd.add;
  assign hwpe_cfg_master.wen   = r_cmd.wen;
  assign hwpe_cfg_master.be    = r_cmd.be;
  assign hwpe_cfg_master.wdata = r_cmd.wdata;
  assign hwpe_cfg_master.id    = r_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outOfReset <= 1'b0;
      r_req        <= 1'b0;
      r_cmd        <= '{wen: 1'b1, add: '0, wdata: '0, be: '0};
      r_id         <= '0;
      r_idCnt      <= '0;
      r_tmo        <= '0;
      r_rsp        <= '0;
    end else begin
      r_outOfReset <= 1'b1;
      r_req        <= (w_nextState == ST_REQ);

      if (r_state != w_nextState) begin
        r_tmo <= '0;
      end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
        r_tmo <= r_tmo + TW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cmdFire) begin
            r_cmd   <= '{wen: cmd_wen_i, add: cmd_add_i, wdata: cmd_wdata_i, be: cmd_be_i};
            r_id    <= r_idCnt;
            r_idCnt <= r_idCnt + ID_WIDTH'(1);
          end
        end
        ST_REQ: begin
          if (!hwpe_cfg_master.gnt && w_timeout) begin
            r_rsp.rdata <= '0;
            r_rsp.err   <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Write responses carry no data; a stale or foreign r_id flags an error.
          if (hwpe_cfg_master.r_valid) begin
            r_rsp.rdata <= r_cmd.wen ? hwpe_cfg_master.r_rdata : '0;
            r_rsp.err   <= (hwpe_cfg_master.r_id != r_id);
          end else if (w_timeout) begin
            r_rsp.rdata <= '0;
            r_rsp.err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
